adder_inverse_seq: RTL and testbench



---
 rtl/adder_inverse_seq.sv | 107 ++++++++++
 tb/tb_adder_inverse_seq.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/adder_inverse_seq.sv
// Multi-cycle chunked subtractor: diff = sum - a, CHUNK bits per cycle with a registered borrow.
// Build option: define ADDER_INVERSE_SAT_EN to clamp diff to zero when the result underflows.
module adder_inverse_seq #(
    parameter int unsigned WIDTH = 125,
    parameter int unsigned CHUNK = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH:0]   sum,
    input  logic [WIDTH-1:0] a,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   diff,
    output logic             underflow
);

    localparam int unsigned SUM_W  = WIDTH + 1;
    localparam int unsigned NCHUNK = (SUM_W + CHUNK - 1) / CHUNK;
    localparam int unsigned IDX_W  = $clog2(NCHUNK + 1);
    localparam logic [SUM_W-1:0] CMASK = SUM_W'({CHUNK{1'b1}});

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [SUM_W-1:0]   sum_q;
    logic [SUM_W-1:0]   a_q;
    logic [IDX_W-1:0]   idx;
    logic               borrow;

    logic [31:0]        base_c;
    logic [CHUNK:0]     part_c;
    logic [SUM_W-1:0]   diff_next_c;

    // One chunk of the borrow chain; the top chunk reads zero-filled bits past the MSB,
    // so its borrow out equals the borrow out of the top result bit.
    always_comb begin
        base_c      = 32'(idx) * CHUNK;
        part_c      = {1'b0, CHUNK'(sum_q >> base_c)}
                    - {1'b0, CHUNK'(a_q >> base_c)}
                    - (CHUNK + 1)'(borrow);
        diff_next_c = (diff & ~(CMASK << base_c))
                    | (SUM_W'(part_c[CHUNK-1:0]) << base_c);
    end

    // idx runs 0..NCHUNK-1 computing chunks; the idx==NCHUNK cycle publishes the result.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            diff      <= '0;
            underflow <= 1'b0;
            idx       <= '0;
            borrow    <= 1'b0;
            sum_q     <= '0;
            a_q       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        sum_q    <= sum;
                        a_q      <= SUM_W'(a);
                        borrow   <= 1'b0;
                        idx      <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    if (idx == IDX_W'(NCHUNK)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        underflow <= borrow;
`ifdef ADDER_INVERSE_SAT_EN
                        if (borrow) begin
                            diff <= '0;
                        end
`endif
                    end else begin
                        diff   <= diff_next_c;
                        borrow <= part_c[CHUNK];
                        idx    <= idx + IDX_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adder_inverse_seq.sv
// Directed vector bench for adder_inverse_seq (expects the saturated result when ADDER_INVERSE_SAT_EN is defined).
module tb_adder_inverse_seq;

    localparam int unsigned WIDTH = 125;
    localparam int unsigned NVEC  = 8;
    localparam int LAT   = 5;
`ifdef ADDER_INVERSE_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] a;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   diff;
    logic             underflow;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [WIDTH:0]   s;
        logic [WIDTH-1:0] av;
        logic [WIDTH:0]   d;
        logic             uf;
    } vec_t;

    vec_t vecs [NVEC];

    adder_inverse_seq #(.WIDTH(WIDTH), .CHUNK(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sum       (sum),
        .a         (a),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one operation and return the number of edges from accept until out_valid.
    task automatic start_op(input logic [WIDTH:0] s, input logic [WIDTH-1:0] av, output int lat);
        sum      = s;
        a        = av;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat      = 0;
        while (!out_valid && lat < 50) begin
            tick();
            lat++;
        end
    endtask

    initial begin
        logic [WIDTH:0] ones;
        logic [WIDTH:0] one;
        logic [WIDTH:0] d_hold;
        logic           uf_hold;
        int             lat;
        int             seen;

        ones = '1;
        one  = 1;

        vecs[0] = '{s: 126'd300, av: 125'd100, d: 126'd200, uf: 1'b0};
        vecs[1] = '{s: one << 32, av: 125'd1, d: 126'hFFFF_FFFF, uf: 1'b0};
        vecs[2] = '{s: (one << 125) + 126'd5, av: 125'd6, d: (one << 125) - 126'd1, uf: 1'b0};
        vecs[3] = '{s: 126'd0, av: 125'd1, d: SAT ? 126'd0 : ones, uf: 1'b1};
        vecs[4] = '{s: (one << 125) - 126'd1, av: '1, d: 126'd0, uf: 1'b0};
        vecs[5] = '{s: ones, av: '1, d: one << 125, uf: 1'b0};
        vecs[6] = '{s: 126'd5, av: '1, d: SAT ? 126'd0 : (one << 125) + 126'd6, uf: 1'b1};
        vecs[7] = '{s: one << 96, av: 125'd1, d: (one << 96) - 126'd1, uf: 1'b0};

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        sum       = '0;
        a         = '0;
        tick();
        tick();
        check("reset in_ready", 128'(in_ready), 128'(1));
        check("reset out_valid", 128'(out_valid), 128'(0));
        check("reset diff", 128'(diff), 128'(0));
        check("reset underflow", 128'(underflow), 128'(0));
        reset = 1'b0;
        tick();

        for (int i = 0; i < int'(NVEC); i++) begin
            check($sformatf("vec%0d in_ready before", i), 128'(in_ready), 128'(1));
            out_ready = 1'b1;
            start_op(vecs[i].s, vecs[i].av, lat);
            check($sformatf("vec%0d latency", i), 128'(lat), 128'(LAT));
            check($sformatf("vec%0d diff", i), 128'(diff), 128'(vecs[i].d));
            check($sformatf("vec%0d underflow", i), 128'(underflow), 128'(vecs[i].uf));
            tick();
            check($sformatf("vec%0d out_valid drop", i), 128'(out_valid), 128'(0));
            out_ready = 1'b0;
        end

        // Backpressure: result held for 10 cycles while a competing input is offered.
        out_ready = 1'b0;
        start_op(126'd1000, 125'd1, lat);
        check("bp latency", 128'(lat), 128'(LAT));
        check("bp diff", 128'(diff), 128'(999));
        sum      = 126'd77;
        a        = 125'd3;
        in_valid = 1'b1;
        d_hold   = diff;
        uf_hold  = underflow;
        for (int c = 0; c < 10; c++) begin
            tick();
            check($sformatf("bp hold%0d", c),
                  128'({out_valid, in_ready, underflow, diff}),
                  128'({1'b1, 1'b0, uf_hold, d_hold}));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp out_valid drop", 128'(out_valid), 128'(0));
        check("bp in_ready back", 128'(in_ready), 128'(1));
        out_ready = 1'b0;

        // Reset during the second RUN cycle discards the operation.
        sum      = 126'd50;
        a        = 125'd7;
        in_valid = 1'b1;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst out_valid", 128'(out_valid), 128'(0));
        check("midrst in_ready", 128'(in_ready), 128'(1));
        check("midrst diff", 128'(diff), 128'(0));
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            if (out_valid) seen++;
            tick();
        end
        check("midrst no out_valid", 128'(seen), 128'(0));
        start_op(126'd9, 125'd4, lat);
        check("post-reset latency", 128'(lat), 128'(LAT));
        check("post-reset diff", 128'(diff), 128'(5));
        check("post-reset underflow", 128'(underflow), 128'(0));
        tick();
        out_ready = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
